// File: rtl/dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram_ctrl
// Purpose  : Word-organised SRAM data-memory slave for the core dmem port,
//            answering each request after WAIT_STATES wait cycles.
//            Optional error responses are enabled by DMEM_SRAM_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_sram_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmem_valid_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_wstrb_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_ready_o,
    output logic        dmem_err_o,
    output logic        busy_o
);

    localparam int          c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_wstrb;
    logic           r_ready;
    logic           r_err;
    logic [31:0]    r_rdata;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_idle;
    logic           w_enter_resp;
    logic           w_src_we;
    logic [31:0]    w_src_addr;
    logic [31:0]    w_src_wdata;
    logic [3:0]     w_src_wstrb;
    logic [31:0]    w_offset;
    logic [c_AW-1:0] w_idx;
    logic           w_err;
    logic [31:0]    w_resp_rdata;
    logic           w_unused_bits;

    // With zero wait states the response is formed straight from the live
    // inputs in IDLE; otherwise only the captured request is used.
    assign w_idle       = (r_state == S_IDLE);
    assign w_src_we     = w_idle ? dmem_we_i    : r_we;
    assign w_src_addr   = w_idle ? dmem_addr_i  : r_addr;
    assign w_src_wdata  = w_idle ? dmem_wdata_i : r_wdata;
    assign w_src_wstrb  = w_idle ? dmem_wstrb_i : r_wstrb;

    assign w_enter_resp = (w_idle && dmem_valid_i && (c_WAIT == 4'd0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd1));

    assign w_offset      = w_src_addr - BASE_ADDR;
    assign w_idx         = w_offset[c_AW+1:2];
    assign w_unused_bits = ^{w_offset[31:c_AW+2], w_offset[1:0]};

`ifdef DMEM_SRAM_ERR_EN
    localparam logic [31:0] c_SPAN = 32'(DEPTH_WORDS * 4);
    logic [3:0] w_low_mask;

    // Byte lanes below the addressed byte must not be strobed.
    always_comb begin
        w_low_mask = 4'b0000;
        case (w_src_addr[1:0])
            2'd1:    w_low_mask = 4'b0001;
            2'd2:    w_low_mask = 4'b0011;
            2'd3:    w_low_mask = 4'b0111;
            default: w_low_mask = 4'b0000;
        endcase
    end

    assign w_err = (w_offset >= c_SPAN) ||
                   ((w_src_addr[1:0] != 2'd0) &&
                    (!w_src_we || ((w_src_wstrb & w_low_mask) != 4'b0000)));
`else
    assign w_err = 1'b0;
`endif

    assign w_resp_rdata = (w_src_we || w_err) ? 32'h0000_0000 : r_mem[w_idx];

    // Array is deliberately not reset; the commit shares the RESP-entry edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_enter_resp && w_src_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_src_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_src_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_wstrb <= 4'b0000;
            r_ready <= 1'b0;
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0000_0000;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dmem_valid_i) begin
                        r_we    <= dmem_we_i;
                        r_addr  <= dmem_addr_i;
                        r_wdata <= dmem_wdata_i;
                        r_wstrb <= dmem_wstrb_i;
                        r_cnt   <= c_WAIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_enter_resp) begin
                r_state <= S_RESP;
                r_ready <= 1'b1;
                r_rdata <= w_resp_rdata;
                r_err   <= w_err;
            end
        end
    end

    assign dmem_ready_o = r_ready;
    assign dmem_rdata_o = r_rdata;
    assign dmem_err_o   = r_err;
    assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sram_ctrl
// Purpose  : Self-checking bench for dmem_sram_ctrl (vector table, corner
//            sequences and randomized traffic against a word-array model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_sram_ctrl;

    localparam int          c_DEPTH = 1024;
    localparam int          c_WAIT  = 2;
    localparam logic [31:0] c_BASE  = 32'h0000_0000;
    localparam int          c_INIT_WORDS = 32;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        dmem_valid_i = 1'b0;
    logic        dmem_we_i = 1'b0;
    logic [31:0] dmem_addr_i = 32'h0;
    logic [31:0] dmem_wdata_i = 32'h0;
    logic [3:0]  dmem_wstrb_i = 4'h0;
    logic [31:0] dmem_rdata_o;
    logic        dmem_ready_o;
    logic        dmem_err_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [c_DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    dmem_sram_ctrl #(
        .DEPTH_WORDS (c_DEPTH),
        .WAIT_STATES (c_WAIT),
        .BASE_ADDR   (c_BASE)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .dmem_valid_i (dmem_valid_i),
        .dmem_we_i    (dmem_we_i),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_wstrb_i (dmem_wstrb_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_ready_o (dmem_ready_o),
        .dmem_err_o   (dmem_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Reference model: plain byte-address arithmetic on a word array.
    task automatic model_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output logic [31:0] rd, output logic er);
        int unsigned off;
        int unsigned idx;
        int unsigned lane;
        off  = addr - c_BASE;
        idx  = (off / 4) % c_DEPTH;
        lane = addr % 4;
        er   = 1'b0;
        rd   = 32'h0;
`ifdef DMEM_SRAM_ERR_EN
        if (off >= c_DEPTH * 4) er = 1'b1;
        if (!we && lane != 0) er = 1'b1;
        if (we && lane != 0 && (int'(wstrb) % (1 << lane)) != 0) er = 1'b1;
`else
        if (lane > 3) er = 1'b1;
`endif
        if (!er) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = model_mem[idx];
            end
        end
    endtask

    // Issue one request from an idle cycle (called #1 after a rising edge);
    // returns #1 after the edge that starts the following idle cycle.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [31:0] exp_rd, input logic exp_er);
        int          lat;
        logic [31:0] rd;
        logic        er;
        lat = 0;
        rd  = 32'h0;
        er  = 1'b0;
        dmem_valid_i = 1'b1;
        dmem_we_i    = we;
        dmem_addr_i  = addr;
        dmem_wdata_i = wdata;
        dmem_wstrb_i = wstrb;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk({name, " busy"}, {31'b0, busy_o}, 32'd1);
            if (dmem_ready_o) begin
                lat = k;
                rd  = dmem_rdata_o;
                er  = dmem_err_o;
                dmem_valid_i = 1'b0;
            end else begin
                dmem_valid_i = 1'($urandom);
                dmem_we_i    = 1'($urandom);
                dmem_addr_i  = $urandom;
                dmem_wdata_i = $urandom;
                dmem_wstrb_i = 4'($urandom);
            end
        end
        dmem_valid_i = 1'b0;
        chk({name, " latency"}, 32'(lat), 32'(c_WAIT + 1));
        chk({name, " rdata"}, rd, exp_rd);
        chk({name, " err"}, {31'b0, er}, {31'b0, exp_er});
        @(posedge clk); #1;
        chk({name, " idle after resp"}, {30'b0, busy_o, dmem_ready_o}, 32'd0);
    endtask

    task automatic model_and_req(input string name, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] rd;
        logic        er;
        model_req(we, addr, wdata, wstrb, rd, er);
        do_req(name, we, addr, wdata, wstrb, rd, er);
    endtask

    initial begin
        logic [31:0] mrd;
        logic        mer;
        logic [31:0] exp4;
        int          got;

        for (int i = 0; i < c_DEPTH; i++) model_mem[i] = 32'h0;

        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b1, 32'h14,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h14,   32'h0,        4'h0, 32'h10050505, 1'b0};
        vecs[10] = '{1'b1, 32'h11,   32'hAABBCCDD, 4'hE, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hAABBCC44, 1'b0};
`ifdef DMEM_SRAM_ERR_EN
        vecs[6]  = '{1'b0, 32'h1010, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 32'h1000, 32'h55AA55AA, 4'hF, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h10000000, 1'b0};
        vecs[12] = '{1'b1, 32'h12,   32'h12345678, 4'h3, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hAABBCC44, 1'b0};
`else
        vecs[6]  = '{1'b0, 32'h1010, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[7]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[8]  = '{1'b1, 32'h1000, 32'h55AA55AA, 4'hF, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h55AA55AA, 1'b0};
        vecs[12] = '{1'b1, 32'h12,   32'h12345678, 4'h3, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hAABBCC78, 1'b0};
`endif
`ifndef DMEM_SRAM_ERR_EN
        vecs[13].exp_rdata = 32'hAABB5678;
`endif

        // Power-on reset, checked before any clock edge.
        #1 rst_i = 1'b1;
        #1;
        chk("reset state", {dmem_rdata_o[31:0]}, 32'h0);
        chk("reset flags", {29'b0, dmem_ready_o, dmem_err_o, busy_o}, 32'd0);
        #20 rst_i = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < c_INIT_WORDS; i++)
            model_and_req("init write", 1'b1, 32'(i * 4), init_val(i), 4'hF);

        for (int i = 0; i < 14; i++) begin
            model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, mrd, mer);
            do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].wstrb, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Held valid: one response per WAIT+2 cycles; addr only correct in IDLE cycles.
        exp4 = model_mem[4];
        dmem_valid_i = 1'b1;
        dmem_we_i    = 1'b0;
        dmem_addr_i  = 32'h10;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
            chk($sformatf("held valid ready c%0d", c), {31'b0, dmem_ready_o},
                {31'b0, 1'((c % 4) == 3)});
            if (dmem_ready_o) chk($sformatf("held valid rdata c%0d", c), dmem_rdata_o, exp4);
            dmem_addr_i = ((c % 4) == 0) ? 32'h10 : (32'h40 + 32'($urandom_range(0, 15)) * 4);
            if (c == 11) dmem_valid_i = 1'b0;
        end
        @(posedge clk); #1;

        // Reset during the wait phase of a write: no response, write lost.
        dmem_valid_i = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_addr_i  = 32'h20;
        dmem_wdata_i = 32'hCAFEF00D;
        dmem_wstrb_i = 4'hF;
        @(posedge clk); #1;
        dmem_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("reset mid-write async", {30'b0, busy_o, dmem_ready_o}, 32'd0);
        #10 rst_i = 1'b0;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (dmem_ready_o) got++;
        end
        chk("no ready after reset", 32'(got), 32'd0);
        model_and_req("read after aborted write", 1'b0, 32'h20, 32'h0, 4'h0);

        // Reset while the response is on the bus clears it without an edge.
        dmem_valid_i = 1'b1;
        dmem_we_i    = 1'b0;
        dmem_addr_i  = 32'h10;
        @(posedge clk); #1;
        dmem_valid_i = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            if (dmem_ready_o) got = 1;
            else begin @(posedge clk); #1; end
        end
        chk("resp before reset", dmem_rdata_o, model_mem[4]);
        #2 rst_i = 1'b1;
        #1;
        chk("reset in resp rdata", dmem_rdata_o, 32'h0);
        chk("reset in resp flags", {29'b0, dmem_ready_o, dmem_err_o, busy_o}, 32'd0);
        #10 rst_i = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic inside the initialised window and its alias.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 127)))
                                            : 32'($urandom_range(0, 127));
            model_and_req($sformatf("rand%0d", i), 1'($urandom), a, $urandom, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
